sv32_ptw: RTL and testbench

// Sv32 hardware page-table walker: the read-side initiator for the data memory's page-table port.

---
 rtl/sv32_ptw_pkg.sv | 25 ++
 rtl/sv32_ptw.sv | 106 ++++++++++
 tb/tb_sv32_ptw.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sv32_ptw_pkg.sv
// sv32_ptw_pkg: Sv32 PTE bit indices, access/cause codes, walker states and the PTE check.
package sv32_ptw_pkg;
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam logic [1:0] ACC_LOAD  = 2'b00;
  localparam logic [1:0] ACC_STORE = 2'b01;
  localparam logic [1:0] ACC_RSVD  = 2'b11;
  localparam logic [1:0] CAUSE_OK = 2'b00;
  localparam logic [1:0] CAUSE_PF = 2'b01;
  localparam logic [1:0] CAUSE_AF = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_L1, S_L0, S_RESP} state_t;
  // OK for a non-leaf only at level 1 (walk continues); U is left to the MMU.
  function automatic logic [1:0] pte_leaf_check(input logic [31:0] pte, input logic [1:0] acc, input logic level);
    logic perm;
    perm = acc == ACC_LOAD ? pte[PTE_R] : acc == ACC_STORE ? pte[PTE_W] & pte[PTE_D] : pte[PTE_X];
    if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]) || acc == ACC_RSVD) return CAUSE_PF;
    if (!(pte[PTE_R] || pte[PTE_X])) return level ? CAUSE_OK : CAUSE_PF;
    if (level && pte[19:10] != 10'd0) return CAUSE_PF;
    return (perm && pte[PTE_A]) ? CAUSE_OK : CAUSE_PF;
  endfunction
endpackage

// File: rtl/sv32_ptw.sv
// sv32_ptw: Sv32 two-level page-table walker reading PTEs through one dmem read port.
import sv32_ptw_pkg::*;
module sv32_ptw #(
  parameter int DATA_WHITH = 32,
  parameter int ADDR_WHITH = 10,
  parameter int PA_WIDTH   = 34
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_vaddr,
  input  logic [1:0]            req_acc,
  input  logic                  satp_mode,
  input  logic [21:0]           satp_ppn,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [PA_WIDTH-1:0]   resp_paddr,
  output logic [1:0]            resp_cause,
  output logic [ADDR_WHITH-1:0] mem_addr,
  input  logic [DATA_WHITH-1:0] mem_rdata,
  input  logic                  mem_busy
);
  state_t                r_state;
  logic [21:0]           r_vaddr;
  logic [1:0]            r_acc;
  logic [ADDR_WHITH-1:0] r_mem_addr;
  logic                  r_resp_valid;
  logic [PA_WIDTH-1:0]   r_paddr;
  logic [1:0]            r_cause;
  logic [PA_WIDTH-3:0]   w_l1_word, w_l0_word;
  logic                  w_l1_oob, w_l0_oob, w_leaf;
  logic [1:0]            w_chk;
  // Word addresses: byte address >> 2, so the upper-bit range check drops two bits too.
  assign w_l1_word = {satp_ppn, 10'b0} + {22'b0, req_vaddr[31:22]};
  assign w_l0_word = {mem_rdata[31:10], 10'b0} + {22'b0, r_vaddr[21:12]};
  assign w_l1_oob  = |w_l1_word[PA_WIDTH-3:ADDR_WHITH];
  assign w_l0_oob  = |w_l0_word[PA_WIDTH-3:ADDR_WHITH];
  assign w_leaf    = mem_rdata[PTE_R] | mem_rdata[PTE_X];
  assign w_chk     = pte_leaf_check(mem_rdata, r_acc, r_state == S_L1);
  assign req_ready  = (r_state == S_IDLE) & ~flush;
  assign resp_valid = r_resp_valid;
  assign resp_paddr = r_paddr;
  assign resp_cause = r_cause;
  assign mem_addr   = r_mem_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_acc        <= '0;
      r_mem_addr   <= '0;
      r_resp_valid <= 1'b0;
      r_paddr      <= '0;
      r_cause      <= '0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_paddr      <= '0;
      r_cause      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_vaddr <= req_vaddr[21:0];
          r_acc   <= req_acc;
          if (!satp_mode) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_paddr      <= {2'b0, req_vaddr};
            r_cause      <= CAUSE_OK;
          end else if (w_l1_oob) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_cause      <= CAUSE_AF;
          end else begin
            r_state    <= S_L1;
            r_mem_addr <= w_l1_word[ADDR_WHITH-1:0];
          end
        end
        S_L1, S_L0: if (!mem_busy) begin
          if (w_chk == CAUSE_OK && !w_leaf) begin
            if (w_l0_oob) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_cause      <= CAUSE_AF;
            end else begin
              r_state    <= S_L0;
              r_mem_addr <= w_l0_word[ADDR_WHITH-1:0];
            end
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_cause      <= w_chk;
            r_paddr      <= w_chk != CAUSE_OK ? '0 :
                            r_state == S_L1 ? {mem_rdata[31:20], r_vaddr} : {mem_rdata[31:10], r_vaddr[11:0]};
          end
        end
        S_RESP: if (resp_ready) begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_paddr      <= '0;
          r_cause      <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_sv32_ptw.sv
// tb_sv32_ptw: scoreboard bench for sv32_ptw with a 4096-word dmem model.
module tb_sv32_ptw;
  typedef struct {logic [33:0] paddr; logic [1:0] cause; int lat;} exp_t;
  typedef struct {logic [31:0] pte1, pte0, va; logic [1:0] acc; logic mode; logic [33:0] pa; logic [1:0] cause; int lat;} vec_t;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, satp_mode = 1, flush = 0, resp_valid, resp_ready = 1, mem_busy = 0;
  logic [31:0] req_vaddr = 0, mem_rdata;
  logic [1:0] req_acc = 0, resp_cause;
  logic [21:0] satp_ppn = 0;
  logic [33:0] resp_paddr;
  logic [11:0] mem_addr;
  logic [31:0] mem [0:4095];
  logic [11:0] alog[$];
  exp_t exp_q[$];
  int tests = 0, fails = 0;

  sv32_ptw #(.DATA_WHITH(32), .ADDR_WHITH(12), .PA_WIDTH(34)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_acc(req_acc), .satp_mode(satp_mode), .satp_ppn(satp_ppn), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr), .resp_cause(resp_cause),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_busy(mem_busy));

  always #5 clk = ~clk;
  assign mem_rdata = mem_busy ? 32'h0 : mem[mem_addr];

  task automatic setup_mem(input logic [31:0] p1, input logic [31:0] p0);
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[1] = p1;
    mem[12'h401] = p0;
  endtask

  task automatic push(input logic [33:0] p, input logic [1:0] c, input int l);
    exp_t e;
    e.paddr = p; e.cause = c; e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [31:0] va, input logic [1:0] acc, input logic mode);
    alog.delete();
    req_vaddr = va; req_acc = acc; satp_mode = mode; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      alog.push_back(mem_addr);
      if (resp_valid) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (resp_valid !== 0 || resp_paddr !== 0 || resp_cause !== 0 || mem_addr !== 0 || req_ready !== 1) begin
      fails++;
      $display("FAIL reset: v=%b pa=%h c=%b ma=%h rr=%b, want all 0 and rr=1", resp_valid, resp_paddr, resp_cause, mem_addr, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_walks();
    vec_t v[$];
    exp_t e;
    int n;
    v.push_back('{32'h401,      32'h200C7, 32'h00401234, 2'b00, 1'b1, 34'h80234,     2'b00, 3});
    v.push_back('{32'h401,      32'h200C7, 32'h00401234, 2'b01, 1'b1, 34'h80234,     2'b00, 3});
    v.push_back('{32'h401,      32'h2004B, 32'h00401234, 2'b10, 1'b1, 34'h80234,     2'b00, 3});
    v.push_back('{32'h401,      32'h200C7, 32'h00401234, 2'b10, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h100043,   32'h0,     32'h00401234, 2'b00, 1'b1, 34'h401234,    2'b00, 2});
    v.push_back('{32'h100043,   32'h0,     32'h007FFFFC, 2'b00, 1'b1, 34'h7FFFFC,    2'b00, 2});
    v.push_back('{32'h100043,   32'h0,     32'h00401234, 2'b01, 1'b1, 34'h0,         2'b01, 2});
    v.push_back('{32'h100443,   32'h0,     32'h00401234, 2'b00, 1'b1, 34'h0,         2'b01, 2});
    v.push_back('{32'h401,      32'h0,     32'h00401234, 2'b00, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h4000001,  32'h0,     32'h00401234, 2'b00, 1'b1, 34'h0,         2'b10, 2});
    v.push_back('{32'h401,      32'h20003, 32'h00401234, 2'b00, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h401,      32'h20047, 32'h00401234, 2'b01, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h401,      32'h200C5, 32'h00401234, 2'b00, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h401,      32'h200C7, 32'h00401234, 2'b11, 1'b1, 34'h0,         2'b01, 2});
    v.push_back('{32'h401,      32'h401,   32'h00401234, 2'b00, 1'b1, 34'h0,         2'b01, 3});
    v.push_back('{32'h0,        32'h0,     32'hDEADBEEC, 2'b00, 1'b0, 34'h0DEADBEEC, 2'b00, 1});
    foreach (v[i]) begin
      setup_mem(v[i].pte1, v[i].pte0);
      push(v[i].pa, v[i].cause, v[i].lat);
      start(v[i].va, v[i].acc, v[i].mode);
      wait_resp(n);
      e = exp_q.pop_front();
      tests++;
      if (resp_valid !== 1 || resp_paddr !== e.paddr || resp_cause !== e.cause) begin
        fails++;
        $display("FAIL walk%0d resp: v=%b pa=%h c=%b, want pa=%h c=%b", i, resp_valid, resp_paddr, resp_cause, e.paddr, e.cause);
      end
      tests++;
      if (1 + n != e.lat) begin fails++; $display("FAIL walk%0d latency: %0d, want %0d", i, 1 + n, e.lat); end
      if (v[i].mode) begin
        tests++;
        if (alog[0] !== 12'h1) begin fails++; $display("FAIL walk%0d l1 addr: %h, want 001", i, alog[0]); end
      end
      if (v[i].lat == 3) begin
        tests++;
        if (alog[1] !== 12'h401) begin fails++; $display("FAIL walk%0d l0 addr: %h, want 401", i, alog[1]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int n;
    setup_mem(32'h401, 32'h200C7);
    push(34'h80234, 2'b00, 6);
    start(32'h00401234, 2'b00, 1'b1);
    mem_busy = 1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (mem_addr !== 12'h1 || resp_valid !== 0) begin fails++; $display("FAIL stall hold: ma=%h v=%b, want 001 0", mem_addr, resp_valid); end
      @(posedge clk); #1;
    end
    mem_busy = 0;
    wait_resp(n);
    e = exp_q.pop_front();
    tests++;
    if (resp_valid !== 1 || resp_paddr !== e.paddr || resp_cause !== e.cause) begin
      fails++;
      $display("FAIL stall resp: v=%b pa=%h c=%b, want pa=%h c=%b", resp_valid, resp_paddr, resp_cause, e.paddr, e.cause);
    end
    tests++;
    if (4 + n != e.lat) begin fails++; $display("FAIL stall latency: %0d, want %0d", 4 + n, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    setup_mem(32'h401, 32'h200C7);
    resp_ready = 0;
    push(34'h80234, 2'b00, 3);
    start(32'h00401234, 2'b00, 1'b1);
    wait_resp(n);
    e = exp_q.pop_front();
    tests++;
    if (1 + n != e.lat) begin fails++; $display("FAIL bp latency: %0d, want %0d", 1 + n, e.lat); end
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (resp_valid !== 1 || resp_paddr !== e.paddr || resp_cause !== e.cause || req_ready !== 0) begin
        fails++;
        $display("FAIL bp hold: v=%b pa=%h c=%b rr=%b, want 1 %h %b 0", resp_valid, resp_paddr, resp_cause, req_ready, e.paddr, e.cause);
      end
    end
    resp_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (resp_valid !== 0 || req_ready !== 1) begin fails++; $display("FAIL bp release: v=%b rr=%b, want 0 1", resp_valid, req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    exp_t e;
    int n, seen;
    setup_mem(32'h401, 32'h200C7);
    start(32'h00401234, 2'b00, 1'b1);
    @(posedge clk); #1;
    flush = 1;
    #1;
    tests++;
    if (req_ready !== 0) begin fails++; $display("FAIL flush ready: rr=%b, want 0", req_ready); end
    @(posedge clk); #1;
    flush = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen != 0 || req_ready !== 1) begin fails++; $display("FAIL flush abort: resp cycles=%0d rr=%b, want 0 1", seen, req_ready); end
    req_vaddr = 32'h12345678; satp_mode = 0; req_valid = 1; flush = 1;
    #1;
    tests++;
    if (req_ready !== 0) begin fails++; $display("FAIL flush+req ready: rr=%b, want 0", req_ready); end
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL flush+req accepted: resp cycles=%0d, want 0", seen); end
    push(34'h80234, 2'b00, 3);
    start(32'h00401234, 2'b00, 1'b1);
    wait_resp(n);
    e = exp_q.pop_front();
    tests++;
    if (resp_valid !== 1 || resp_paddr !== e.paddr || resp_cause !== e.cause || 1 + n != e.lat) begin
      fails++;
      $display("FAIL flush recover: v=%b pa=%h c=%b lat=%0d, want pa=%h c=%b lat=%0d", resp_valid, resp_paddr, resp_cause, 1 + n, e.paddr, e.cause, e.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    setup_mem(32'h401, 32'h200C7);
    start(32'h00401234, 2'b00, 1'b1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    tests++;
    if (resp_valid !== 0 || resp_paddr !== 0 || resp_cause !== 0 || mem_addr !== 0 || req_ready !== 1) begin
      fails++;
      $display("FAIL async reset: v=%b pa=%h c=%b ma=%h rr=%b, want all 0 and rr=1", resp_valid, resp_paddr, resp_cause, mem_addr, req_ready);
    end
    #2 rst_n = 1;
    @(posedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard leftover: %0d, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_walks();
    test_stall();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
